// File: rtl/decap_pkg.sv
// rtl/decap_pkg.sv - shared types and constants for the decapsulation sequencer
package decap_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CMP    = 3'd3,
    OUT    = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Fixed key value released on rejection when no rejection key is wired in
  localparam int REJ_CONST = 1;

  // Selects what key_out carries on a rejected decapsulation
  localparam int REJ_MODE_CONST = 0;
  localparam int REJ_MODE_KEY   = 1;

endpackage

// File: rtl/ct_hash_cmp.sv
// rtl/ct_hash_cmp.sv - serial constant-time hash comparator, one CMP_W slice per cycle
module ct_hash_cmp
  import decap_pkg::*;
#(
  parameter int HASH_W = 128,
  parameter int CMP_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [HASH_W-1:0] a,
  input  logic [HASH_W-1:0] b,
  output logic              done,
  output logic              neq
);

  localparam int N_SL  = HASH_W / CMP_W;
  localparam int IDX_W = (N_SL > 1) ? $clog2(N_SL) : 1;

  logic [IDX_W-1:0]  idx;
  logic              active;
  logic              acc;
  logic [HASH_W-1:0] x_shift;
  logic              slice_ne;

  // The slice is picked by shifting the full XOR, so every slice costs the same
  assign x_shift  = (a ^ b) >> (CMP_W * int'(idx));
  assign slice_ne = |x_shift[CMP_W-1:0];

  // Final slice folds in combinationally so the owner can register the verdict on the same edge
  assign done = active && (idx == IDX_W'(N_SL - 1));
  assign neq  = acc | slice_ne;

  // Walk every slice regardless of intermediate results; no early exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      idx    <= '0;
      acc    <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      idx    <= '0;
      acc    <= 1'b0;
    end else if (active) begin
      acc <= acc | slice_ne;
      if (done) begin
        active <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decap_seq_ctrl.sv
// rtl/decap_seq_ctrl.sv - SNTRUP decapsulation stage sequencer with constant-time confirmation check
module decap_seq_ctrl
  import decap_pkg::*;
#(
  parameter int N_STAGES   = 7,
  parameter int WCHK_STAGE = 5,
  parameter int HASH_W     = 128,
  parameter int KEY_W      = 128,
  parameter int CMP_W      = 32,
  parameter int REJ_MODE   = 0,
  parameter int WDOG_W     = 24,
  localparam int SEL_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic [N_STAGES-1:0] stage_start,
  input  logic [N_STAGES-1:0] stage_done,
  output logic [SEL_W-1:0]    stage_sel,
  input  logic                weight_ok,
  input  logic [HASH_W-1:0]   c_hash,
  input  logic [HASH_W-1:0]   cp_hash,
  input  logic [KEY_W-1:0]    ck_key,
  input  logic [KEY_W-1:0]    rej_key,
  output logic [KEY_W-1:0]    key_out,
  output logic                done,
  output logic                reject,
  output logic                error
);

  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(N_STAGES - 1);
  localparam logic [SEL_W-1:0]  WCHK_IDX = SEL_W'(WCHK_STAGE);
  localparam logic [WDOG_W-1:0] WD_MAX   = '1;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                fail_q, fail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                reject_q, reject_d;
  logic                error_q, error_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [N_STAGES-1:0] sstart_q, sstart_d;

  logic                cmp_go;
  logic                cmp_done;
  logic                cmp_neq;
  logic                rej_now;
  logic [KEY_W-1:0]    rej_val;

  assign rej_val = (REJ_MODE == REJ_MODE_KEY) ? rej_key : KEY_W'(REJ_CONST);

  ct_hash_cmp #(
    .HASH_W (HASH_W),
    .CMP_W  (CMP_W)
  ) u_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (cmp_go),
    .a     (c_hash),
    .b     (cp_hash),
    .done  (cmp_done),
    .neq   (cmp_neq)
  );

  // Next-state and next-output decode; every output is produced from a register
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdog_d   = wdog_q;
    fail_d   = fail_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    reject_d = reject_q;
    error_d  = error_q;
    key_d    = key_q;
    sstart_d = '0;
    cmp_go   = 1'b0;
    rej_now  = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d  = LAUNCH;
          idx_d    = '0;
          wdog_d   = '0;
          busy_d   = 1'b1;
          fail_d   = 1'b0;
          error_d  = 1'b0;
          reject_d = 1'b0;
          key_d    = '0;
          sstart_d = N_STAGES'(1);
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        wdog_d  = '0;
      end
      WAIT: begin
        if (stage_done[idx_q]) begin
          if (idx_q == WCHK_IDX && !weight_ok) begin
            fail_d = 1'b1;
          end
          wdog_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = CMP;
            cmp_go  = 1'b1;
          end else begin
            state_d  = LAUNCH;
            idx_d    = idx_q + 1'b1;
            sstart_d = N_STAGES'(1) << (idx_q + 1'b1);
          end
        end else if (wdog_q == WD_MAX - 1'b1) begin
          // Counter would saturate this cycle: the stage is considered hung
          state_d = ERR;
          wdog_d  = WD_MAX;
          busy_d  = 1'b0;
          error_d = 1'b1;
          key_d   = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      CMP: begin
        if (cmp_done) begin
          rej_now  = fail_q | cmp_neq;
          state_d  = OUT;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          reject_d = rej_now;
          key_d    = rej_now ? rej_val : ck_key;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wdog_q   <= '0;
      fail_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      error_q  <= 1'b0;
      key_q    <= '0;
      sstart_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wdog_q   <= wdog_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      error_q  <= error_d;
      key_q    <= key_d;
      sstart_q <= sstart_d;
    end
  end

  assign busy        = busy_q;
  assign stage_start = sstart_q;
  assign stage_sel   = idx_q;
  assign key_out     = key_q;
  assign done        = done_q;
  assign reject      = reject_q;
  assign error       = error_q;

endmodule
